cache_arbiter: RTL and testbench

//  Shares one physical-memory port (cacheline adaptor) between the I-cache and D-cache miss paths.

---
 rtl/cache_arbiter_pkg.sv | 5 +
 rtl/cache_arbiter.sv | 70 +++++++
 tb/tb_cache_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_arbiter_pkg.sv
// arb_types: state and grant encodings shared by the cache arbiter.
package arb_types;
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} arb_state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;
endpackage

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin sharing of one line-memory port between I-cache fills and D-cache fills/write-backs.
module cache_arbiter
  import arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);
  arb_state_t state_q, state_d;
  grant_t     last_q, last_d;
  logic       i_req, d_req;
  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= GRANT_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end
  // IDLE always lasts at least one cycle so a just-completed owner cannot be re-granted
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (state_q == IDLE) begin
      if (i_req && (!d_req || last_q == GRANT_D)) begin
        state_d = SERVE_I;
        last_d  = GRANT_I;
      end else if (d_req) begin
        state_d = SERVE_D;
        last_d  = GRANT_D;
      end
    end else if (mem_resp) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    mem_read     = (state_q == SERVE_I) | ((state_q == SERVE_D) & d_pmem_read & ~d_pmem_write);
    mem_write    = (state_q == SERVE_D) & d_pmem_write;
    mem_address  = (state_q == SERVE_D) ? d_pmem_address : i_pmem_address;
    mem_wdata    = d_pmem_wdata;
    i_pmem_resp  = (state_q == SERVE_I) & mem_resp;
    d_pmem_resp  = (state_q == SERVE_D) & mem_resp;
    i_pmem_rdata = mem_rdata;
    d_pmem_rdata = mem_rdata;
  end
  a_i_held: assert property (@(posedge clk) disable iff (rst) (state_q == SERVE_I) |-> i_req);
  a_d_held: assert property (@(posedge clk) disable iff (rst) (state_q == SERVE_D) |-> d_req);
  a_d_rw:   assert property (@(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write));
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus a random-stall soak checked against a transaction-level owner model.
module tb_cache_arbiter;
  logic         clk = 0, rst = 1;
  logic         i_pmem_read = 0, i_pmem_resp;
  logic [31:0]  i_pmem_address = 0;
  logic [255:0] i_pmem_rdata;
  logic         d_pmem_read = 0, d_pmem_write = 0, d_pmem_resp;
  logic [31:0]  d_pmem_address = 0;
  logic [255:0] d_pmem_wdata = 0, d_pmem_rdata;
  logic         mem_read, mem_write, mem_resp = 0;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata, mem_rdata = 0;
  int checks = 0, errors = 0;

  cache_arbiter dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // model: who owns the memory port (0 none, 1 I, 2 D) and who was granted last
  int  m_own = 0, m_last = 2;
  bit  live = 0;
  logic i_want, d_want;
  assign i_want = i_pmem_read;
  assign d_want = d_pmem_read | d_pmem_write;

  always @(posedge clk) begin
    if (rst) begin
      m_own = 0;
      m_last = 2;
      live = 1;
    end else if (m_own == 0) begin
      if (i_want && d_want) m_own = (m_last == 1) ? 2 : 1;
      else if (i_want) m_own = 1;
      else if (d_want) m_own = 2;
      if (m_own != 0) m_last = m_own;
    end else if (mem_resp) m_own = 0;
  end

  always @(negedge clk) if (live) begin
    chk("mem_read", mem_read, (m_own == 1) || (m_own == 2 && d_pmem_read && !d_pmem_write));
    chk("mem_write", mem_write, m_own == 2 && d_pmem_write);
    chk("i_resp", i_pmem_resp, m_own == 1 && mem_resp);
    chk("d_resp", d_pmem_resp, m_own == 2 && mem_resp);
    if (m_own != 0) chk("mem_address", mem_address, (m_own == 1) ? i_pmem_address : d_pmem_address);
    if (m_own == 2 && d_pmem_write) chk("mem_wdata", mem_wdata, d_pmem_wdata);
    if (i_pmem_resp) chk("i_rdata", i_pmem_rdata, mem_rdata);
    if (d_pmem_resp) chk("d_rdata", d_pmem_rdata, mem_rdata);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [255:0] pat_a, r1;
    int issued = 0, done = 0, i_wait = 0, d_wait = 0, stall = 0, cyc = 0;
    bit busy = 0, ir, dr, mreq, ireq_s, dreq_s, was_resp;
    pat_a = {8{32'hA5A5_5A5A}};
    r1 = {8{32'h1234_5678}};
    step();
    step();
    @(negedge clk);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_i_resp", i_pmem_resp, 0);
    chk("rst_d_resp", d_pmem_resp, 0);
    step();
    rst = 0;
    // 1: I-only read, resp after 4 SERVE cycles
    i_pmem_read = 1;
    i_pmem_address = 32'h0000_1000;
    @(negedge clk);
    chk("t1_idle_cycle", mem_read, 0);
    step();
    @(negedge clk);
    chk("t1_mem_read", mem_read, 1);
    chk("t1_addr", mem_address, 32'h0000_1000);
    step(); step(); step();
    mem_resp = 1;
    mem_rdata = r1;
    @(negedge clk);
    chk("t1_i_resp", i_pmem_resp, 1);
    chk("t1_i_rdata", i_pmem_rdata, r1);
    step();
    i_pmem_read = 0;
    mem_resp = 0;
    @(negedge clk);
    chk("t1_resp_pulse", i_pmem_resp, 0);
    chk("t1_back_idle", mem_read, 0);
    // 2: D write-back
    d_pmem_write = 1;
    d_pmem_address = 32'h8000_00E0;
    d_pmem_wdata = pat_a;
    step();
    @(negedge clk);
    chk("t2_mem_write", mem_write, 1);
    chk("t2_mem_read", mem_read, 0);
    chk("t2_wdata", mem_wdata, pat_a);
    chk("t2_addr", mem_address, 32'h8000_00E0);
    step();
    mem_resp = 1;
    @(negedge clk);
    chk("t2_d_resp", d_pmem_resp, 1);
    chk("t2_i_resp", i_pmem_resp, 0);
    step();
    d_pmem_write = 0;
    mem_resp = 0;
    // 3: tie from reset goes to I, then D, then next tie to I again
    rst = 1;
    step();
    rst = 0;
    i_pmem_read = 1;
    i_pmem_address = 32'h0000_2000;
    d_pmem_read = 1;
    d_pmem_address = 32'h0000_3000;
    step();
    mem_resp = 1;
    @(negedge clk);
    chk("t3_first_i", mem_address, 32'h0000_2000);
    chk("t3_i_resp", i_pmem_resp, 1);
    chk("t3_d_quiet", d_pmem_resp, 0);
    step();
    i_pmem_read = 0;
    mem_resp = 0;
    @(negedge clk);
    chk("t3_gap", mem_read, 0);
    step();
    mem_resp = 1;
    @(negedge clk);
    chk("t3_then_d", mem_address, 32'h0000_3000);
    chk("t3_d_resp", d_pmem_resp, 1);
    step();
    d_pmem_read = 0;
    mem_resp = 0;
    step();
    i_pmem_read = 1;
    d_pmem_read = 1;
    step();
    // 4: D pending during SERVE_I never steals the port
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_hold_i", mem_address, 32'h0000_2000);
      step();
    end
    mem_resp = 1;
    @(negedge clk);
    chk("t4_i_resp", i_pmem_resp, 1);
    step();
    i_pmem_read = 0;
    mem_resp = 0;
    @(negedge clk);
    chk("t4_gap", mem_read, 0);
    step();
    @(negedge clk);
    chk("t4_d_now", mem_address, 32'h0000_3000);
    chk("t4_d_read", mem_read, 1);
    // 5: reset 2 cycles into SERVE_D
    step();
    step();
    rst = 1;
    d_pmem_read = 0;
    step();
    @(negedge clk);
    chk("t5_read", mem_read, 0);
    chk("t5_write", mem_write, 0);
    chk("t5_resp", d_pmem_resp, 0);
    rst = 0;
    step();
    i_pmem_read = 1;
    i_pmem_address = 32'h0000_4000;
    step();
    mem_resp = 1;
    @(negedge clk);
    chk("t5_post_i", mem_address, 32'h0000_4000);
    chk("t5_post_resp", i_pmem_resp, 1);
    step();
    i_pmem_read = 0;
    mem_resp = 0;
    // 6: stray mem_resp in IDLE
    step();
    mem_resp = 1;
    @(negedge clk);
    chk("t6_no_i", i_pmem_resp, 0);
    chk("t6_no_d", d_pmem_resp, 0);
    step();
    mem_resp = 0;
    @(negedge clk);
    chk("t6_still_idle", mem_read | mem_write, 0);
    // soak: random requests and stalls
    while ((done < 1000 || done != issued) && cyc < 60000) begin
      cyc++;
      @(negedge clk);
      ir = i_pmem_resp;
      dr = d_pmem_resp;
      mreq = mem_read | mem_write;
      ireq_s = i_pmem_read;
      dreq_s = d_pmem_read | d_pmem_write;
      if (ir) begin
        chk("soak_i_resp_req", i_pmem_read, 1);
        chk("soak_i_starve", i_wait <= 1, 1);
        i_wait = 0;
        done++;
        if (dreq_s) d_wait++;
      end
      if (dr) begin
        chk("soak_d_resp_req", dreq_s, 1);
        chk("soak_d_starve", d_wait <= 1, 1);
        d_wait = 0;
        done++;
        if (ireq_s) i_wait++;
      end
      step();
      if (ir) i_pmem_read = 0;
      if (dr) begin
        d_pmem_read = 0;
        d_pmem_write = 0;
      end
      was_resp = mem_resp;
      if (mem_resp) begin
        mem_resp = 0;
        busy = 0;
      end else if (mreq) begin
        if (!busy) begin
          busy = 1;
          stall = $urandom_range(0, 4);
        end
        if (stall == 0) mem_resp = 1;
        else stall--;
      end
      mem_rdata = rnd256();
      if (!ir && !i_pmem_read && issued < 1000 && $urandom_range(0, 2) == 0) begin
        i_pmem_read = 1;
        i_pmem_address = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
        issued++;
      end
      if (!dr && !d_pmem_read && !d_pmem_write && issued < 1000 && $urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 1) d_pmem_write = 1;
        else d_pmem_read = 1;
        d_pmem_address = {$urandom_range(0, 32'h07FF_FFFF), 5'b0};
        d_pmem_wdata = rnd256();
        issued++;
      end
      if (!was_resp && !mreq && !ireq_s && !dreq_s && !i_pmem_read && !d_pmem_read && !d_pmem_write
          && $urandom_range(0, 7) == 0) mem_resp = 1;
    end
    chk("soak_all_done", done, 1000);
    chk("soak_matched", done, issued);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
